uart_v2_rx: RTL and testbench

UART_V2_RX -- requirements
Module: uart_v2_rx

---
 rtl/uart_v2_rx.sv | 153 +++++++++++++++
 tb/tb_uart_v2_rx.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_v2_rx.sv
// 4x-oversampled UART receiver (8N1, LSB first) with sticky framing/overrun flags.
// The line is double-synchronized; every sampling decision is made on rx_s2.
module uart_v2_rx #(
  parameter int DATA_BITS = 8
) (
  input  logic       uart_sample_clk,
  input  logic       sysreset,
  input  logic       rx_line,
  input  logic       ack,
  output logic [7:0] parallel_out,
  output logic       data_ready,
  output logic       framing_error,
  output logic       overrun,
  output logic       rx_busy
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

  state_t     state_r, state_nx;
  logic       rx_s1, rx_s2;
  logic [1:0] cnt_r, cnt_nx;
  logic [2:0] idx_r, idx_nx;
  logic [7:0] shift_r, shift_nx;
  logic       load_s, ferr_s;

  // Two-flop synchronizer; resets to the idle-high line level.
  always_ff @(posedge uart_sample_clk or negedge sysreset) begin
    if (!sysreset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= rx_line;
      rx_s2 <= rx_s1;
    end
  end

  // FSM state, sample counter, bit index and shift register.
  always_ff @(posedge uart_sample_clk or negedge sysreset) begin
    if (!sysreset) begin
      state_r <= IDLE;
      cnt_r   <= 2'd0;
      idx_r   <= 3'd0;
      shift_r <= 8'h00;
      rx_busy <= 1'b0;
    end else begin
      state_r <= state_nx;
      cnt_r   <= cnt_nx;
      idx_r   <= idx_nx;
      shift_r <= shift_nx;
      rx_busy <= (state_nx != IDLE);
    end
  end

  // Next-state logic: START decides at cnt 1 (mid start bit), later bits at cnt 3.
  always_comb begin
    state_nx = state_r;
    cnt_nx   = cnt_r + 2'd1;
    idx_nx   = idx_r;
    shift_nx = shift_r;
    load_s   = 1'b0;
    ferr_s   = 1'b0;
    case (state_r)
      IDLE: begin
        cnt_nx = 2'd0;
        if (!rx_s2) state_nx = START;
        else        state_nx = IDLE;
      end
      START: begin
        if (cnt_r == 2'd1) begin
          cnt_nx = 2'd0;
          idx_nx = 3'd0;
          if (!rx_s2) state_nx = DATA;
          else        state_nx = IDLE;
        end else begin
          state_nx = START;
        end
      end
      DATA: begin
        if (cnt_r == 2'd3) begin
          shift_nx[idx_r] = rx_s2;
          if (idx_r == LAST_IDX) begin
            idx_nx   = 3'd0;
            state_nx = STOP;
          end else begin
            idx_nx   = idx_r + 3'd1;
            state_nx = DATA;
          end
        end else begin
          state_nx = DATA;
        end
      end
      STOP: begin
        if (cnt_r == 2'd3) begin
          if (rx_s2) begin
            load_s   = 1'b1;
            state_nx = IDLE;
          end else begin
            ferr_s   = 1'b1;
            state_nx = WAIT_IDLE;
          end
        end else begin
          state_nx = STOP;
        end
      end
      WAIT_IDLE: begin
        cnt_nx = 2'd0;
        if (rx_s2) state_nx = IDLE;
        else       state_nx = WAIT_IDLE;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = 2'd0;
        idx_nx   = 3'd0;
      end
    endcase
  end

  // Output byte and flags; a completing frame takes priority over a coincident ack.
  always_ff @(posedge uart_sample_clk or negedge sysreset) begin
    if (!sysreset) begin
      parallel_out  <= 8'h00;
      data_ready    <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else if (load_s) begin
      parallel_out  <= shift_r;
      data_ready    <= 1'b1;
      overrun       <= ack ? 1'b0 : (overrun | data_ready);
      framing_error <= framing_error & ~ack;
    end else if (ferr_s) begin
      framing_error <= 1'b1;
      data_ready    <= data_ready & ~ack;
      overrun       <= overrun & ~ack;
    end else if (ack) begin
      data_ready    <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      data_ready    <= data_ready;
      framing_error <= framing_error;
      overrun       <= overrun;
    end
  end

endmodule

// File: tb/tb_uart_v2_rx.sv
// Scoreboard bench for uart_v2_rx: frames push expected bytes, a monitor pops them
// when the receiver publishes a byte, and directed checks cover flags and reset.
module tb_uart_v2_rx;
  localparam int DATA_BITS = 8;
  localparam int LATENCY   = 41;  // line fall after edge t0 -> E = t0+3 -> data_ready at E+38

  logic       clk = 1'b0;
  logic       sysreset = 1'b0;
  logic       rx_line = 1'b1;
  logic       ack = 1'b0;
  logic [7:0] parallel_out;
  logic       data_ready, framing_error, overrun, rx_busy;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  typedef struct {
    logic [7:0] data;
    logic       ovr;
    int         due;
  } exp_t;
  exp_t sb[$];

  uart_v2_rx #(.DATA_BITS(DATA_BITS)) dut (
    .uart_sample_clk(clk),
    .sysreset       (sysreset),
    .rx_line        (rx_line),
    .ack            (ack),
    .parallel_out   (parallel_out),
    .data_ready     (data_ready),
    .framing_error  (framing_error),
    .overrun        (overrun),
    .rx_busy        (rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    step(1);
    ack = 1'b0;
  endtask

  // Drives one frame starting just after the current edge; returns 40 edges later.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                            input logic push, input logic exp_ovr);
    exp_t e;
    if (push) begin
      e.data = d;
      e.ovr  = exp_ovr;
      e.due  = cyc + LATENCY;
      sb.push_back(e);
    end
    rx_line = 1'b0;
    step(4);
    for (int i = 0; i < DATA_BITS; i++) begin
      rx_line = d[i];
      step(4);
    end
    rx_line = stop_bit;
    step(4);
  endtask

  // Monitor: a rising data_ready or a new parallel_out value is a published byte.
  initial begin
    logic       prev_dr;
    logic [7:0] prev_po;
    exp_t       e;
    prev_dr = 1'b0;
    prev_po = 8'h00;
    forever begin
      @(negedge clk);
      if (sysreset && ((data_ready && !prev_dr) || (parallel_out != prev_po))) begin
        check_val("sb_pending", (sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check_val("sb_data", parallel_out, e.data);
          check_val("sb_ready", data_ready, 1);
          check_val("sb_overrun", overrun, e.ovr);
          check_val("sb_latency", cyc, e.due);
        end
      end
      prev_dr = data_ready;
      prev_po = parallel_out;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    step(3);
    check_val("rst_po", parallel_out, 8'h00);
    check_val("rst_dr", data_ready, 0);
    check_val("rst_fe", framing_error, 0);
    check_val("rst_ov", overrun, 0);
    check_val("rst_busy", rx_busy, 0);
    sysreset = 1'b1;
    step(4);

    // Plain byte, then ack keeps the byte but drops data_ready
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
    step(2);
    check_val("a5_fe", framing_error, 0);
    ack_pulse();
    check_val("a5_ack_dr", data_ready, 0);
    check_val("a5_ack_po", parallel_out, 8'hA5);
    step(3);

    // One-clock glitch is rejected at mid start bit
    rx_line = 1'b0;
    step(1);
    rx_line = 1'b1;
    step(2);
    check_val("glitch_busy_on", rx_busy, 1);
    step(2);
    check_val("glitch_busy_off", rx_busy, 0);
    check_val("glitch_dr", data_ready, 0);
    check_val("glitch_fe", framing_error, 0);
    check_val("glitch_po", parallel_out, 8'hA5);
    step(4);

    // Framing error followed by a held break, then a good byte
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    step(80);
    check_val("fe_set", framing_error, 1);
    check_val("fe_po", parallel_out, 8'hA5);
    check_val("fe_dr", data_ready, 0);
    check_val("fe_break_busy", rx_busy, 1);
    rx_line = 1'b1;
    step(4);
    check_val("fe_idle_busy", rx_busy, 0);
    check_val("fe_sticky", framing_error, 1);
    ack_pulse();
    check_val("fe_ack", framing_error, 0);
    send_frame(8'h55, 1'b1, 1'b1, 1'b0);
    step(3);
    check_val("b55_fe", framing_error, 0);
    ack_pulse();
    step(2);

    // Back-to-back bytes without ack -> overrun
    send_frame(8'h11, 1'b1, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b1, 1'b1);
    step(2);
    check_val("ovr_po", parallel_out, 8'h22);
    check_val("ovr_dr", data_ready, 1);
    check_val("ovr_ov", overrun, 1);
    ack_pulse();
    check_val("ovr_ack_dr", data_ready, 0);
    check_val("ovr_ack_ov", overrun, 0);
    check_val("ovr_ack_po", parallel_out, 8'h22);
    step(3);

    // Ack lands on the completion edge of the second byte: new byte wins
    send_frame(8'h33, 1'b1, 1'b1, 1'b0);
    step(4);
    send_frame(8'h7E, 1'b1, 1'b1, 1'b0);
    ack_pulse();
    step(1);
    check_val("ackwin_dr", data_ready, 1);
    check_val("ackwin_ov", overrun, 0);
    check_val("ackwin_po", parallel_out, 8'h7E);
    ack_pulse();
    step(2);

    // Reset in the middle of 0xFF, then 0x81
    rx_line = 1'b0;
    step(4);
    rx_line = 1'b1;
    step(18);
    check_val("mid_busy", rx_busy, 1);
    sysreset = 1'b0;
    #1;
    check_val("mrst_po", parallel_out, 8'h00);
    check_val("mrst_dr", data_ready, 0);
    check_val("mrst_fe", framing_error, 0);
    check_val("mrst_ov", overrun, 0);
    check_val("mrst_busy", rx_busy, 0);
    step(3);
    sysreset = 1'b1;
    step(4);
    check_val("post_rst_busy", rx_busy, 0);
    check_val("post_rst_dr", data_ready, 0);
    send_frame(8'h81, 1'b1, 1'b1, 1'b0);
    step(3);
    check_val("b81_po", parallel_out, 8'h81);
    check_val("b81_fe", framing_error, 0);
    check_val("b81_ov", overrun, 0);

    step(5);
    check_val("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
